seq_divider_16: RTL and testbench
=================================

// Module: seq_divider_16
// PURPOSE
//  Iterative restoring divider: the subtract-direction counterpart of the team's 16-bit
//  carry-lookahead fast adder. Divides an unsigned 16-bit dividend by a 16-bit divisor, one quotient bit per clock.
//  Each step performs one WIDTH+1-bit trial subtract (rem + ~divisor + 1). The carry-out acts as the not-borrow.
//  Sits beside the ALU as a multi-cycle DIV/REM unit under a start/done handshake.
// PARAMETERS
//  WIDTH  16  operand, quotient and remainder width; also the iteration count
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      synchronous reset, active-high
//  start        in   1      request; sampled only when busy=0
//  dividend     in   WIDTH  numerator; captured on an accepted start
//  divisor      in   WIDTH  denominator; captured on an accepted start
//  busy         out  1      high from the cycle after acceptance until done is pulsed (inclusive)
//  done         out  1      one-cycle pulse; quotient/remainder valid in the same cycle
//  quotient     out  WIDTH  result; held until the next accepted start
//  remainder    out  WIDTH  result; held until the next accepted start
//  div_by_zero  out  1      set with done when the captured divisor==0; held like the results
// BEHAVIOUR
//  - Reset: state=IDLE. busy, done, div_by_zero, quotient, remainder, and the iteration counter all return to 0.
//  - FSM: IDLE -> CALC on start & divisor!=0. IDLE -> FIN on start & divisor==0.
//    CALC -> CALC while count<WIDTH-1. CALC -> FIN after the WIDTH-th step. FIN -> IDLE always.
//  - Acceptance cycle t0 (start=1 in IDLE): latch operands, rem=0, q=dividend, count=0.
//  - CALC step: sh={rem[W-2:0],q[W-1]}. d=sh+~divisor+1, computed WIDTH+1 wide.
//    If carry-out=1: rem=d[W-1:0] and shift 1 into q. Else: rem=sh and shift 0 into q.
//  - Latency: done=1 at cycle t0+WIDTH+1 (17 for default). Divide-by-zero case: done at t0+1.
//  - Divide-by-zero results: quotient=all ones, remainder=dividend, div_by_zero=1 (RISC-V semantics).
//  - start while busy=1 is ignored: no re-capture, result unaffected.
//  - start in the same cycle done=1 (FIN) is ignored. It is accepted on the next IDLE cycle.
//  - rst mid-operation aborts at the next edge. No done is produced and all outputs clear.
//  - done is never high for two consecutive cycles.
// CONFIGURATION
//  SEQ_DIV_SIGNED_EN defined:
//   - Adds input is_signed (1 bit), captured with the operands.
//   - With is_signed=1, operands are converted to magnitudes before CALC.
//   - In FIN, the quotient is negated if the operand signs differ, and the remainder takes the dividend's sign.
//   - Overflow 0x8000 / 0xFFFF gives quotient=0x8000, remainder=0.
//   - Divide-by-zero gives quotient=0xFFFF, remainder=dividend.
//   - Latency is unchanged.
//  SEQ_DIV_SIGNED_EN undefined: no is_signed port; unsigned only.
// TESTING
//  1. dividend=100, divisor=7, start at t0 -> done at t0+17, quotient=14, remainder=2, div_by_zero=0.
//  2. 0xFFFF / 0x0001 -> quotient=0xFFFF, remainder=0. Then 0x0003 / 0xFFFF -> quotient=0, remainder=3.
//  3. 0x1234 / 0 -> done at t0+1, quotient=0xFFFF, remainder=0x1234, div_by_zero=1.
//  4. Start 100/7, then pulse start with 50/5 at t0+5 -> single done at t0+17 with 14/2.
//     busy stays high throughout.
//  5. Start 100/7, assert rst at t0+8 -> next cycle: busy=0, quotient=0, remainder=0. No done ever appears.
//  6. With SEQ_DIV_SIGNED_EN, is_signed=1: 0xFFF9 / 2 -> quotient=0xFFFD, remainder=0xFFFF.
//     0x8000 / 0xFFFF -> quotient=0x8000, remainder=0.

Source files
------------

// File: rtl/seq_divider_16.sv
// seq_divider_16: iterative restoring divider, one quotient bit per clock,
// under a start/done handshake. Divide-by-zero follows RISC-V semantics
// (quotient all ones, remainder = dividend).
// Optional feature macro: SEQ_DIV_SIGNED_EN adds an is_signed input for
// two's-complement division with the same latency.
module seq_divider_16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef SEQ_DIV_SIGNED_EN
    input  logic             is_signed,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    // Working remainder drops its MSB: before each shift it is below 2^(k)
    // with k < WIDTH, so bit WIDTH-1 is always zero while iterating.
    logic [WIDTH-2:0] rem_q, rem_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;
    logic             dbz_q, dbz_d;
`ifdef SEQ_DIV_SIGNED_EN
    logic             neg_q_q, neg_q_d;   // quotient needs negation
    logic             neg_r_q, neg_r_d;   // remainder takes dividend's sign
    logic [WIDTH-1:0] a_mag, b_mag;
`endif

    logic [WIDTH-1:0] sh;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] rem_step, q_step;
    logic [WIDTH-1:0] fin_q, fin_r;

    // Trial subtract, operand capture, FSM sequencing and result formatting.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rem_d   = rem_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        dbz_d   = dbz_q;

        // Carry-out of the WIDTH+1 bit subtract is the not-borrow.
        sh   = {rem_q, q_q[WIDTH-1]};
        diff = {1'b0, sh} + {1'b0, ~dvs_q} + (WIDTH+1)'(1);
        if (diff[WIDTH]) begin
            rem_step = diff[WIDTH-1:0];
            q_step   = {q_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_step = sh;
            q_step   = {q_q[WIDTH-2:0], 1'b0};
        end

`ifdef SEQ_DIV_SIGNED_EN
        neg_q_d = neg_q_q;
        neg_r_d = neg_r_q;
        a_mag   = (is_signed && dividend[WIDTH-1]) ? (~dividend + WIDTH'(1)) : dividend;
        b_mag   = (is_signed && divisor[WIDTH-1])  ? (~divisor + WIDTH'(1))  : divisor;
        fin_q   = neg_q_q ? (~q_step + WIDTH'(1))   : q_step;
        fin_r   = neg_r_q ? (~rem_step + WIDTH'(1)) : rem_step;
`else
        fin_q   = q_step;
        fin_r   = rem_step;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        state_d = FIN;
                        quo_d   = '1;
                        rmd_d   = dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = CALC;
                        count_d = '0;
                        rem_d   = '0;
`ifdef SEQ_DIV_SIGNED_EN
                        q_d     = a_mag;
                        dvs_d   = b_mag;
                        neg_q_d = is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        neg_r_d = is_signed && dividend[WIDTH-1];
`else
                        q_d     = dividend;
                        dvs_d   = divisor;
`endif
                    end
                end
            end
            CALC: begin
                rem_d   = rem_step[WIDTH-2:0];
                q_d     = q_step;
                count_d = count_q + CW'(1);
                if (count_q == CW'(WIDTH-1)) begin
                    state_d = FIN;
                    quo_d   = fin_q;
                    rmd_d   = fin_r;
                    dbz_d   = 1'b0;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            rem_q   <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            dbz_q   <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            dbz_q   <= dbz_d;
`ifdef SEQ_DIV_SIGNED_EN
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
`endif
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == FIN);
    assign quotient    = quo_q;
    assign remainder   = rmd_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_16.sv
// Scoreboard bench for seq_divider_16: expected results are queued at launch
// and popped when done is observed; latency and busy are checked alongside.
module tb_seq_divider_16;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [15:0] dividend, divisor;
`ifdef SEQ_DIV_SIGNED_EN
    logic        is_signed;
`endif
    logic        busy, done, div_by_zero;
    logic [15:0] quotient, remainder;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    logic done_prev = 1'b0;

    seq_divider_16 dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
`ifdef SEQ_DIV_SIGNED_EN
        .is_signed  (is_signed),
`endif
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // done must never stay high two cycles running
    always @(negedge clk) begin
        if (done_prev === 1'b1) begin
            checks++;
            if (done !== 1'b0) begin
                failures++;
                $display("FAIL done_double got=%b want=0", done);
            end
        end
        done_prev <= done;
    end

    task automatic push_exp(input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        int   sa, sbv, qi, ri;
        if (b == 16'd0) begin
            e.q = 16'hFFFF; e.r = a; e.dbz = 1'b1;
        end
`ifdef SEQ_DIV_SIGNED_EN
        else if (is_signed) begin
            sa  = int'($signed(a));
            sbv = int'($signed(b));
            qi  = sa / sbv;
            ri  = sa % sbv;
            e.q = qi[15:0]; e.r = ri[15:0]; e.dbz = 1'b0;
        end
`endif
        else begin
            e.q = a / b; e.r = a % b; e.dbz = 1'b0;
        end
        sb.push_back(e);
    endtask

    // Called at a negedge; start is high across exactly one rising edge.
    task automatic launch(input logic [15:0] a, input logic [15:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // n0 = negedges already elapsed since the acceptance edge.
    task automatic wait_done(input string name, input int lat, input int n0);
        exp_t e;
        int   n;
        n = n0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL %s_timeout got_done=%b want=1 after %0d cycles", name, done, n);
        end else if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s_scoreboard_empty got=done want=expected entry", name);
        end else begin
            e = sb.pop_front();
            if (n !== lat) begin
                failures++;
                $display("FAIL %s_latency got=%0d want=%0d", name, n, lat);
            end
            checks++;
            if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
                failures++;
                $display("FAIL %s_result got=q%h r%h z%b want=q%h r%h z%b",
                         name, quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
            end
            checks++;
            if (busy !== 1'b1) begin
                failures++;
                $display("FAIL %s_busy_at_done got=%b want=1", name, busy);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 35'd0) begin
            failures++;
            $display("FAIL reset_state got=b%b d%b q%h r%h z%b want=all zero",
                     busy, done, quotient, remainder, div_by_zero);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        push_exp(16'd100, 16'd7);
        launch(16'd100, 16'd7);
        wait_done("basic_100_7", 17, 1);
        @(negedge clk);
    endtask

    task automatic test_boundary();
        push_exp(16'hFFFF, 16'h0001); launch(16'hFFFF, 16'h0001); wait_done("max_by_1", 17, 1);
        @(negedge clk);
        push_exp(16'h0003, 16'hFFFF); launch(16'h0003, 16'hFFFF); wait_done("small_by_max", 17, 1);
        @(negedge clk);
        push_exp(16'hFFFE, 16'hFFFF); launch(16'hFFFE, 16'hFFFF); wait_done("big_rem", 17, 1);
        @(negedge clk);
    endtask

    task automatic test_div_zero();
        push_exp(16'h1234, 16'h0000);
        launch(16'h1234, 16'h0000);
        wait_done("div_zero", 1, 1);
        @(negedge clk);
    endtask

    task automatic test_busy_ignore();
        int n;
        push_exp(16'd100, 16'd7);
        launch(16'd100, 16'd7);
        n = 1;
        repeat (15) begin
            checks++;
            if (busy !== 1'b1) begin
                failures++;
                $display("FAIL busy_hold got=%b want=1 at cycle %0d", busy, n);
            end
            if (n == 5) begin
                dividend = 16'd50; divisor = 16'd5; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        wait_done("busy_ignore", 17, n);
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        logic seen;
        launch(16'd100, 16'd7);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy, quotient, remainder} !== 33'd0) begin
            failures++;
            $display("FAIL abort_clear got=b%b q%h r%h want=0 0 0", busy, quotient, remainder);
        end
        seen = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_done got=%b want=0", seen);
        end
    endtask

    task automatic test_back_to_back();
        push_exp(16'd200, 16'd9);
        push_exp(16'd1000, 16'd33);
        dividend = 16'd200; divisor = 16'd9; start = 1'b1;
        @(negedge clk);
        wait_done("b2b_first", 17, 1);
        dividend = 16'd1000; divisor = 16'd33;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle_gap got=%b want=0", busy);
        end
        @(negedge clk);
        start = 1'b0;
        wait_done("b2b_second", 18, 2);
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [15:0] a, b;
        for (int i = 0; i < 10; i++) begin
            a = 16'($urandom);
            b = (i % 2 == 1) ? 16'($urandom_range(1, 20)) : 16'($urandom);
            if (i == 7) b = 16'd0;
            push_exp(a, b);
            launch(a, b);
            wait_done("random", (b == 16'd0) ? 1 : 17, 1);
            @(negedge clk);
        end
    endtask

`ifdef SEQ_DIV_SIGNED_EN
    task automatic test_signed();
        is_signed = 1'b1;
        push_exp(16'hFFF9, 16'h0002); launch(16'hFFF9, 16'h0002); wait_done("signed_neg7_by_2", 17, 1);
        @(negedge clk);
        push_exp(16'h8000, 16'hFFFF); launch(16'h8000, 16'hFFFF); wait_done("signed_overflow", 17, 1);
        @(negedge clk);
        push_exp(16'h0007, 16'hFFFE); launch(16'h0007, 16'hFFFE); wait_done("signed_7_by_neg2", 17, 1);
        @(negedge clk);
        push_exp(16'hFFF9, 16'h0000); launch(16'hFFF9, 16'h0000); wait_done("signed_div_zero", 1, 1);
        @(negedge clk);
        is_signed = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
`ifdef SEQ_DIV_SIGNED_EN
        is_signed = 1'b0;
`endif
        @(negedge clk);
        test_reset();
        test_basic();
        test_boundary();
        test_div_zero();
        test_busy_ignore();
        test_reset_abort();
        test_back_to_back();
        test_random();
`ifdef SEQ_DIV_SIGNED_EN
        test_signed();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
